fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer between the program counter and a variable-latency instruction memory. Issues one fetch request at a time, holds the address stable until memory responds, buffers the returned word with its PC, and presents it to the decode stage under a valid/stall handshake. Branch redirects from execute flush in-flight or buffered fetches. It replaces the free-running PC+4 fetch wherever memory is not single-cycle.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `redirect_valid`  in  1: branch/jump taken this cycle.
- `redirect_pc`  in  32: target address; sampled when `redirect_valid`=1.
- `stall`  in  1: decode cannot accept this cycle.
- `out_valid`  out  1: `out_pc`/`out_instr` hold a valid fetched instruction.
- `out_pc`  out  32: PC of the buffered instruction.
- `out_instr`  out  32: buffered instruction word.
- `mem_req`  out  1: fetch request.
- `mem_addr`  out  32: fetch address; stable while `mem_req`=1.
- `mem_ready`  in  1: response this cycle. May assert in the same cycle as the request is first raised (0-wait).
- `mem_rdata`  in  32: instruction word; valid only when `mem_ready`=1.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `state`.
  - `flush_pend` and `pend_pc`: a redirect received during an outstanding request.
  - Output buffer: `out_valid`, `out_pc`, `out_instr`.
- Reset values: `state`=IDLE, `pc`=`RESET_PC`, `flush_pend`=0, `pend_pc`=0, `out_valid`=0, `out_pc`=`RESET_PC`, `out_instr`=32'h0000_0013 (NOP).
- `mem_req`=1 exactly when `state`=FETCH. `mem_addr`=`pc`. Both are decoded from registered state only, with no combinational path from inputs.
- IDLE: advance to FETCH unconditionally on the next edge.
- FETCH, `mem_ready`=0:
  - If `redirect_valid`: set `flush_pend`=1 and `pend_pc`=`redirect_pc`. A later redirect overwrites `pend_pc`.
  - `pc` does not change.
- FETCH, `mem_ready`=1:
  - If `redirect_valid`: discard the data, set `pc`=`redirect_pc`, clear `flush_pend`, stay in FETCH.
  - Else if `flush_pend`: discard the data, set `pc`=`pend_pc`, clear `flush_pend`, stay in FETCH.
  - Otherwise: `out_instr`=`mem_rdata`, `out_pc`=`pc`, `out_valid`=1, `pc`=`pc`+4, go to VALID.
- VALID:
  - If `redirect_valid`: `out_valid`=0, `pc`=`redirect_pc`, go to FETCH. Redirect takes priority over `stall`.
  - Else if `stall`=0: the instruction transfers; `out_valid`=0, go to FETCH.
  - Else hold all outputs.
- Transfer rule: a transfer happens only when `out_valid`=1, `stall`=0 and `redirect_valid`=0. Decode treats `out_valid` in a redirect cycle as a bubble.
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. Redirect targets are taken verbatim; bits [1:0] are passed through unchecked.
- Reset asserted mid-request: `mem_req` drops immediately (asynchronous) and the memory must abandon the request. Any `mem_ready` while in IDLE is ignored.

## Timing
- Fetch latency with 0-wait memory:
  - Cycle N: `mem_req`=1 and `mem_ready`=1.
  - Cycle N+1: `out_valid`=1.
  - Cycle N+2 (if no stall): next `mem_req`.
- Peak throughput is one instruction per 2 cycles; each memory wait state adds 1 cycle.
- Redirect penalty:
  - From VALID: the target request is issued the next cycle.
  - From FETCH: the redirect waits for the outstanding response, then the target request is issued the following cycle.
- After reset release, the first `mem_req` appears on the 2nd rising edge.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_e` enum {IDLE, FETCH, VALID}.
  - `NOP_INSTR` = 32'h0000_0013.
  - `FETCH_ADDR_W` = 32.
- Single flat module; no sub-module. The output buffer and PC are local `always_ff` blocks with asynchronous active-low reset.

## Test plan
- Reset, 0-wait memory returning `addr^32'hA5A5_0000`, `stall`=0 → `mem_addr` sequence 0, 4, 8; `out_valid` pulses every 2nd cycle; `out_pc`=0, 4, 8 with matching `out_instr`.
- 3-wait memory at addr 0x10 → `mem_addr` stays 0x10 for 4 cycles; `out_valid` rises 1 cycle after `mem_ready`.
- In VALID, `stall`=1 for 5 cycles → `out_pc`/`out_instr` stable and no `mem_req`; after `stall`=0, the next fetch is `out_pc`+4.
- `redirect_valid` with `redirect_pc`=0x200 during cycle 1 of a 3-wait fetch at 0x40:
  - `mem_addr` stays 0x40 until `mem_ready`.
  - The response is discarded and `out_valid` stays 0.
  - The next `mem_addr`=0x200.
- Redirect to 0x80 in VALID with `stall`=1 → `out_valid`=0 next cycle; next `mem_addr`=0x80.
- `RESET_PC`=32'hFFFF_FFFC → the second fetch is at 0x0. Assert `reset` while `mem_req`=1 → `mem_req`=0 in the same cycle; all outputs return to their reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer
package fetch_pkg;
   localparam int          FETCH_ADDR_W = 32;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   typedef enum logic [1:0] {IDLE, FETCH, VALID} fetch_state_e;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: one-at-a-time instruction fetch sequencer with redirect flush and a decode-side output buffer
//   clk, reset (async, active low)
//   redirect_valid/redirect_pc : branch redirect from execute
//   stall                      : decode back-pressure
//   out_valid/out_pc/out_instr : buffered instruction to decode
//   mem_req/mem_addr           : fetch request, address held while mem_req=1
//   mem_ready/mem_rdata        : memory response (may coincide with the first request cycle)
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [FETCH_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    redirect_valid,
   input  logic [FETCH_ADDR_W-1:0] redirect_pc,
   input  logic                    stall,
   output logic                    out_valid,
   output logic [FETCH_ADDR_W-1:0] out_pc,
   output logic [31:0]             out_instr,
   output logic                    mem_req,
   output logic [FETCH_ADDR_W-1:0] mem_addr,
   input  logic                    mem_ready,
   input  logic [31:0]             mem_rdata
);
   fetch_state_e            state;
   logic [FETCH_ADDR_W-1:0] pc;
   logic [FETCH_ADDR_W-1:0] pend_pc;
   logic                    flush_pend;
   logic                    accept;
   // a response is kept only if no redirect arrived during or alongside the request
   assign accept   = state == FETCH && mem_ready && !redirect_valid && !flush_pend;
   assign mem_req  = state == FETCH;
   assign mem_addr = pc;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         flush_pend <= 1'b0;
         pend_pc    <= '0;
      end else
         case (state)
            IDLE: state <= FETCH;
            FETCH:
               if (mem_ready) begin
                  flush_pend <= 1'b0;
                  if (redirect_valid) pc <= redirect_pc;
                  else if (flush_pend) pc <= pend_pc;
                  else begin
                     pc    <= pc + 32'd4;
                     state <= VALID;
                  end
               end else if (redirect_valid) begin
                  // request stays outstanding; remember the newest target for after the response
                  flush_pend <= 1'b1;
                  pend_pc    <= redirect_pc;
               end
            VALID:
               if (redirect_valid) begin
                  pc    <= redirect_pc;
                  state <= FETCH;
               end else if (!stall) state <= FETCH;
            default: state <= IDLE;
         endcase
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         out_valid <= 1'b0;
         out_pc    <= RESET_PC;
         out_instr <= NOP_INSTR;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_pc    <= pc;
         out_instr <= mem_rdata;
      end else if (state == VALID && (redirect_valid || !stall))
         out_valid <= 1'b0;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a transaction-level reference
module tb_fetch_ctrl;
   localparam logic [31:0] KEY = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        stall = 1'b0;
   logic        out_valid;
   logic [31:0] out_pc, out_instr;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;

   logic        w_valid, w_req, w_ready;
   logic [31:0] w_pc, w_instr, w_addr, w_rdata;
   logic        w_zero = 1'b0;
   logic [31:0] w_zpc = '0;

   int n_checks = 0;
   int n_fail = 0;
   int wcnt = 0;
   int wait_cfg = 0;
   bit rand_wait = 0;
   logic last_ready;

   always #5 clk = ~clk;

   fetch_ctrl u_dut (
      .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .stall(stall), .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   // second instance: zero-wait memory, start address at the top of the address space
   assign w_ready = w_req;
   assign w_rdata = w_addr ^ KEY;
   fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .reset(reset), .redirect_valid(w_zero), .redirect_pc(w_zpc),
      .stall(w_zero), .out_valid(w_valid), .out_pc(w_pc), .out_instr(w_instr),
      .mem_req(w_req), .mem_addr(w_addr), .mem_ready(w_ready), .mem_rdata(w_rdata)
   );

   // one clock: inputs applied at the falling edge, memory answers after wait_cfg wait states
   task automatic step(input logic rv, input logic [31:0] rpc, input logic st);
      logic req_now;
      redirect_valid = rv;
      redirect_pc    = rpc;
      stall          = st;
      req_now        = mem_req;
      last_ready     = mem_req && (wcnt >= wait_cfg);
      mem_ready      = last_ready;
      mem_rdata      = last_ready ? (mem_addr ^ KEY) : $urandom;
      @(posedge clk);
      @(negedge clk);
      mem_ready      = 1'b0;
      redirect_valid = 1'b0;
      if (req_now && !last_ready) wcnt++;
      else begin
         wcnt = 0;
         if (rand_wait) wait_cfg = $urandom_range(0, 3);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      wcnt = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_instr", out_instr, NOP);
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      reset = 1'b1;
      wcnt = 0;
      chk("idle_no_req", {31'b0, mem_req}, 32'd0);
      step(0, 0, 0);
      chk("first_req", {31'b0, mem_req}, 32'd1);
   endtask

   task automatic test_zero_wait();
      wait_cfg = 0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step(0, 0, 0);
         chk("zw_req", {31'b0, mem_req}, 32'd1);
         chk("zw_addr", mem_addr, 32'(4 * i));
         chk("zw_valid_low", {31'b0, out_valid}, 32'd0);
         step(0, 0, 0);
         chk("zw_valid", {31'b0, out_valid}, 32'd1);
         chk("zw_out_pc", out_pc, 32'(4 * i));
         chk("zw_out_instr", out_instr, 32'(4 * i) ^ KEY);
         chk("zw_no_req", {31'b0, mem_req}, 32'd0);
      end
   endtask

   task automatic test_wait3();
      wait_cfg = 3;
      step(1, 32'h10, 0);
      for (int i = 0; i < 4; i++) begin
         chk("w3_addr", mem_addr, 32'h10);
         chk("w3_req", {31'b0, mem_req}, 32'd1);
         chk("w3_valid_low", {31'b0, out_valid}, 32'd0);
         step(0, 0, 0);
      end
      chk("w3_valid", {31'b0, out_valid}, 32'd1);
      chk("w3_out_pc", out_pc, 32'h10);
      chk("w3_out_instr", out_instr, 32'h10 ^ KEY);
   endtask

   task automatic test_stall();
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1);
         chk("st_valid", {31'b0, out_valid}, 32'd1);
         chk("st_out_pc", out_pc, 32'h10);
         chk("st_out_instr", out_instr, 32'h10 ^ KEY);
         chk("st_no_req", {31'b0, mem_req}, 32'd0);
      end
      step(0, 0, 0);
      chk("st_next_addr", mem_addr, 32'h14);
      chk("st_next_req", {31'b0, mem_req}, 32'd1);
   endtask

   task automatic test_redirect_fetch();
      int k;
      for (k = 0; k < 10 && !out_valid; k++) step(0, 0, 0);
      chk("rf_reach_valid", {31'b0, out_valid}, 32'd1);
      step(1, 32'h40, 0);
      chk("rf_addr40", mem_addr, 32'h40);
      step(1, 32'h200, 0);
      for (int i = 0; i < 3; i++) begin
         chk("rf_hold_addr", mem_addr, 32'h40);
         chk("rf_hold_valid", {31'b0, out_valid}, 32'd0);
         step(0, 0, 0);
      end
      chk("rf_discard", {31'b0, out_valid}, 32'd0);
      chk("rf_req", {31'b0, mem_req}, 32'd1);
      chk("rf_target", mem_addr, 32'h200);
   endtask

   task automatic test_redirect_valid();
      wait_cfg = 0;
      step(0, 0, 0);
      chk("rv_valid", {31'b0, out_valid}, 32'd1);
      chk("rv_out_pc", out_pc, 32'h200);
      step(1, 32'h80, 1);
      chk("rv_valid_drop", {31'b0, out_valid}, 32'd0);
      chk("rv_req", {31'b0, mem_req}, 32'd1);
      chk("rv_target", mem_addr, 32'h80);
   endtask

   task automatic test_reset_mid();
      chk("rm_pre_req", {31'b0, mem_req}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("rm_req", {31'b0, mem_req}, 32'd0);
      chk("rm_valid", {31'b0, out_valid}, 32'd0);
      chk("rm_out_pc", out_pc, 32'h0);
      chk("rm_out_instr", out_instr, NOP);
      chk("rm_mem_addr", mem_addr, 32'h0);
      do_reset();
   endtask

   task automatic test_wrap();
      do_reset();
      step(0, 0, 0);
      chk("wr_req", {31'b0, w_req}, 32'd1);
      chk("wr_addr0", w_addr, 32'hFFFF_FFFC);
      step(0, 0, 0);
      chk("wr_valid", {31'b0, w_valid}, 32'd1);
      chk("wr_out_pc", w_pc, 32'hFFFF_FFFC);
      chk("wr_out_instr", w_instr, 32'hFFFF_FFFC ^ KEY);
      step(0, 0, 0);
      chk("wr_req2", {31'b0, w_req}, 32'd1);
      chk("wr_addr1", w_addr, 32'h0);
   endtask

   // reference: next expected fetch address, optional deferred redirect target, and the buffered instruction
   task automatic test_random();
      logic [31:0] exp_addr, pend, eq_pc, eq_instr, rpc;
      logic        ev, has_pend, rv, st;
      int          transfers;
      do_reset();
      rand_wait = 1;
      wait_cfg = $urandom_range(0, 3);
      step(0, 0, 0);
      exp_addr = 32'h0;
      ev = 0;
      has_pend = 0;
      pend = '0;
      eq_pc = '0;
      eq_instr = '0;
      transfers = 0;
      for (int c = 0; c < 600; c++) begin
         rv  = $urandom_range(0, 7) == 0;
         rpc = $urandom;
         st  = $urandom_range(0, 2) == 0;
         chk("rnd_valid", {31'b0, out_valid}, {31'b0, ev});
         chk("rnd_req", {31'b0, mem_req}, {31'b0, !ev});
         if (ev) begin
            chk("rnd_out_pc", out_pc, eq_pc);
            chk("rnd_out_instr", out_instr, eq_instr);
         end else chk("rnd_addr", mem_addr, exp_addr);
         step(rv, rpc, st);
         if (ev) begin
            if (rv) begin
               exp_addr = rpc;
               ev = 0;
            end else if (!st) begin
               ev = 0;
               transfers++;
            end
         end else if (last_ready) begin
            if (rv) begin
               exp_addr = rpc;
               has_pend = 0;
            end else if (has_pend) begin
               exp_addr = pend;
               has_pend = 0;
            end else begin
               eq_pc = exp_addr;
               eq_instr = exp_addr ^ KEY;
               exp_addr = exp_addr + 32'd4;
               ev = 1;
            end
         end else if (rv) begin
            has_pend = 1;
            pend = rpc;
         end
      end
      n_checks++;
      if (transfers == 0) begin
         n_fail++;
         $display("FAIL rnd_transfers: got %0d expected nonzero", transfers);
      end
      rand_wait = 0;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait3();
      test_stall();
      test_redirect_fetch();
      test_redirect_valid();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
